inert_seq: RTL and testbench

Sequencer that owns the `SPI_mnrch` SPI main and drives it to configure and poll the iNEMO inertial sensor. After reset it waits a power-up settle interval, then issues four configuration writes. It then waits for the sensor's data-ready `INT` and reads the pitch, roll and yaw rate registers as six single-byte SPI transactions. It assembles each rate into a signed 16-bit word and pulses `vld` when a full sample set is latched. It sits between the `SPI_mnrch` instance and the downstream inertial integrator.

---
 rtl/inert_seq.sv | 186 ++++++++++++++++++
 tb/tb_inert_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inert_seq.sv
// inert_seq: drives the SPI_mnrch main to configure and poll the iNEMO
// inertial sensor. After a power-up settle interval it issues four config
// writes, then for every data-ready INT it reads the pitch/roll/yaw rate
// registers (low byte, then high byte) and presents them as signed 16-bit
// words, pulsing vld once per completed sample set.
//
// Optional feature: define INERT_ACCEL_EN to add the ax/ay outputs and
// extend the read sequence with the accel X/Y registers.
//
// Handshake with SPI_mnrch: wrt is a one-cycle start strobe, raised only
// when no transaction is pending; cmd is valid in the wrt cycle and held
// until done. done counts only while a transaction is pending; any other
// done pulse is ignored. The next wrt may follow in the cycle after done.
`timescale 1ns/1ps

module inert_seq #(
  parameter int SETTLE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] roll_rt,
  output logic [15:0] yaw_rt,
`ifdef INERT_ACCEL_EN
  output logic [15:0] ax,
  output logic [15:0] ay,
`endif
  output logic        vld,
  output logic        init_done,
  output logic [1:0]  state_dbg
);

`ifdef INERT_ACCEL_EN
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_RD = IDX_W'(9);
`else
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_RD = IDX_W'(5);
`endif
  localparam logic [IDX_W-1:0] LAST_CFG = IDX_W'(3);

  typedef enum logic [1:0] {
    SETTLE   = 2'd0,
    CFG      = 2'd1,
    WAIT_INT = 2'd2,
    RD       = 2'd3
  } state_t;

  state_t              state, nxt_state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                int_ff1, int_ff2;
  logic                pend;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          hold_lo;
  logic [15:0]         cfg_word;
  logic [7:0]          rd_addr;
  logic                txn_done;

  assign state_dbg = state;
  assign txn_done  = pend & done;
  // Read register addresses start at A2 and step by one per transaction.
  assign rd_addr   = 8'hA2 + {{(8-IDX_W){1'b0}}, idx};

  // Configuration word table, indexed by the step counter.
  always_comb begin
    cfg_word = 16'h0D02;
    case (idx[1:0])
      2'd0: cfg_word = 16'h0D02;
      2'd1: cfg_word = 16'h1062;
      2'd2: cfg_word = 16'h1162;
      2'd3: cfg_word = 16'h1460;
      default: cfg_word = 16'h0D02;
    endcase
  end

  // Next-state logic; wrt and cmd are decoded from registered state so
  // they drop to zero the instant reset is asserted.
  always_comb begin
    nxt_state = state;
    wrt       = 1'b0;
    cmd       = 16'h0000;
    case (state)
      SETTLE: begin
        if (&settle_cnt) nxt_state = CFG;
      end
      CFG: begin
        wrt = ~pend;
        cmd = cfg_word;
        if (txn_done && idx == LAST_CFG) nxt_state = WAIT_INT;
      end
      WAIT_INT: begin
        if (int_ff2) nxt_state = RD;
      end
      RD: begin
        wrt = ~pend;
        cmd = {rd_addr, 8'h00};
        if (txn_done && idx == LAST_RD) nxt_state = WAIT_INT;
      end
      default: nxt_state = SETTLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SETTLE;
    else        state <= nxt_state;
  end

  // Power-up settle counter, runs only while settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                settle_cnt <= '0;
    else if (state == SETTLE)  settle_cnt <= settle_cnt + SETTLE_W'(1);
  end

  // Two-flop synchronizer for the asynchronous data-ready pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1 <= 1'b0;
      int_ff2 <= 1'b0;
    end else begin
      int_ff1 <= INT;
      int_ff2 <= int_ff1;
    end
  end

  // Outstanding-transaction flag: set by wrt, cleared by the matching done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pend <= 1'b0;
    else if (wrt)  pend <= 1'b1;
    else if (done) pend <= 1'b0;
  end

  // Step index: advances per completed transaction, restarts on phase change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        idx <= '0;
    else if (txn_done) idx <= (nxt_state != state) ? '0 : idx + IDX_W'(1);
  end

  // init_done latches when the last config write completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   init_done <= 1'b0;
    else if (state == CFG && nxt_state == WAIT_INT) init_done <= 1'b1;
  end

  // Capture read bytes: even steps park the low byte, odd steps publish
  // {high, low} so an output never shows a half-updated word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_lo <= 8'h00;
      ptch_rt <= 16'h0000;
      roll_rt <= 16'h0000;
      yaw_rt  <= 16'h0000;
`ifdef INERT_ACCEL_EN
      ax      <= 16'h0000;
      ay      <= 16'h0000;
`endif
    end else if (state == RD && txn_done) begin
      if (!idx[0]) begin
        hold_lo <= rd_data[7:0];
      end else begin
        case (idx)
          IDX_W'(1): ptch_rt <= {rd_data[7:0], hold_lo};
          IDX_W'(3): roll_rt <= {rd_data[7:0], hold_lo};
          IDX_W'(5): yaw_rt  <= {rd_data[7:0], hold_lo};
`ifdef INERT_ACCEL_EN
          IDX_W'(7): ax      <= {rd_data[7:0], hold_lo};
          IDX_W'(9): ay      <= {rd_data[7:0], hold_lo};
`endif
          default: hold_lo <= hold_lo;
        endcase
      end
    end
  end

  // vld pulses in the cycle after the final high-byte capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld <= 1'b0;
    else        vld <= (state == RD) && txn_done && (idx == LAST_RD);
  end

endmodule

// File: tb/tb_inert_seq.sv
// tb_inert_seq: directed bench for inert_seq with a small SPI/iNEMO model.
`timescale 1ns/1ps

module tb_inert_seq;

  localparam int SETTLE_W = 4;
`ifdef INERT_ACCEL_EN
  localparam int NRD = 10;
`else
  localparam int NRD = 6;
`endif

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd, ptch_rt, roll_rt, yaw_rt;
`ifdef INERT_ACCEL_EN
  logic [15:0] ax, ay;
`endif
  logic        vld, init_done;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  inert_seq #(.SETTLE_W(SETTLE_W)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt),
`ifdef INERT_ACCEL_EN
    .ax(ax), .ay(ay),
`endif
    .vld(vld), .init_done(init_done), .state_dbg(state_dbg)
  );

  // Scoreboard state
  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int rd_ix = 0;

  // SPI / sensor model state (written only by the model process)
  logic [7:0]  regs [0:127];
  logic        busy = 1'b0;
  logic [15:0] cur_cmd = 16'h0000;
  logic [15:0] last_done_cmd = 16'h0000;
  int          lat = 0;
  int          done_total = 0;
  int          overlap_err = 0;
  int          spur_done_n = 0;
  // Written only by the main process
  int          spur_req_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // SPI main + sensor model: accepts wrt, answers with done after 1-4 cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      done = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (busy) begin
        if (wrt) overlap_err++;
        if (lat == 0) begin
          done = 1'b1;
          busy = 1'b0;
          last_done_cmd = cur_cmd;
          done_total++;
          rd_data = cur_cmd[15] ? {8'h5A, regs[cur_cmd[14:8]]} : 16'h0000;
        end else begin
          lat--;
        end
      end else if (wrt) begin
        busy = 1'b1;
        cur_cmd = cmd;
        got_q.push_back(cmd);
        lat = $urandom_range(0, 3);
      end else if (spur_req_n != spur_done_n) begin
        done = 1'b1;
        spur_done_n++;
      end
    end
  end

  // Compare the next command the model saw against the expected queue.
  task automatic check_cmd(input string tag);
    logic [15:0] obs;
    logic [15:0] e;
    e   = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
    obs = (got_q.size() > rd_ix) ? got_q[rd_ix] : 16'hxxxx;
    rd_ix++;
    check(tag, obs, e);
  endtask

  task automatic push_reads();
    logic [7:0] a;
    for (int i = 0; i < NRD; i++) begin
      a = 8'hA2 + 8'(i);
      exp_q.push_back({a, 8'h00});
    end
  endtask

  task automatic check_reads(input string tag);
    push_reads();
    for (int i = 0; i < NRD; i++) check_cmd(tag);
  endtask

  // Release is done by the caller at a negedge; first wrt expected 16 cycles on.
  task automatic settle_cfg(input string tag);
    check({tag, "_state_settle"}, state_dbg, 2'd0);
    repeat (15) @(posedge clk);
    #1 check({tag, "_settle_quiet"}, wrt, 1'b0);
    @(posedge clk);
    #1 check({tag, "_first_wrt"}, wrt, 1'b1);
    check({tag, "_first_cmd"}, cmd, 16'h0D02);
    for (int i = 0; i < 200; i++) begin
      if (init_done) break;
      @(posedge clk);
      #1;
    end
    check({tag, "_init_done"}, init_done, 1'b1);
    check({tag, "_init_state"}, state_dbg, 2'd2);
    exp_q.push_back(16'h0D02);
    exp_q.push_back(16'h1062);
    exp_q.push_back(16'h1162);
    exp_q.push_back(16'h1460);
    for (int i = 0; i < 4; i++) check_cmd({tag, "_cfg_cmd"});
  endtask

  // Follow one read sequence until vld; report when pitch first changed
  // and how many transactions completed by the vld cycle.
  task automatic run_seq(input logic [15:0] old_ptch, output int ndone,
                         output logic [15:0] pch_when, output logic seen);
    int base;
    base = done_total;
    pch_when = 16'h0000;
    seen = 1'b0;
    ndone = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (ptch_rt !== old_ptch && pch_when == 16'h0000) pch_when = last_done_cmd;
      if (vld) begin
        seen = 1'b1;
        ndone = done_total - base;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          ndone;
    int          extra_vld;
    logic [15:0] pch_when;
    logic        seen;

    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    regs[7'h22] = 8'h00; regs[7'h23] = 8'h80;
    regs[7'h24] = 8'h78; regs[7'h25] = 8'h56;
    regs[7'h26] = 8'h34; regs[7'h27] = 8'h12;
    regs[7'h28] = 8'hCD; regs[7'h29] = 8'hAB;
    regs[7'h2A] = 8'h11; regs[7'h2B] = 8'h22;

    // Reset held 3 cycles: everything at reset values.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wrt", wrt, 1'b0);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_ptch", ptch_rt, 16'h0000);
    check("rst_roll", roll_rt, 16'h0000);
    check("rst_yaw", yaw_rt, 16'h0000);
    check("rst_vld", vld, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    settle_cfg("boot");

    // Stray done while idle must not disturb the read order.
    spur_req_n++;
    repeat (4) @(posedge clk);
    #1 check("spur_no_wrt", wrt, 1'b0);

    // Sequence 1: INT pulse, pin-to-wrt latency of 3 cycles.
    @(negedge clk);
    INT = 1'b1;
    @(posedge clk);
    #1 check("int_lat1", wrt, 1'b0);
    @(posedge clk);
    #1 check("int_lat2", wrt, 1'b0);
    @(posedge clk);
    #1 check("int_lat3_wrt", wrt, 1'b1);
    check("int_lat3_cmd", cmd, 16'hA200);
    @(negedge clk);
    INT = 1'b0;
    run_seq(16'h0000, ndone, pch_when, seen);
    check("s1_vld_seen", seen, 1'b1);
    check("s1_vld_after_last", ndone, NRD);
    check("s1_ptch_at_A3", pch_when, 16'hA300);
    check("s1_ptch", ptch_rt, 16'h8000);
    check("s1_roll", roll_rt, 16'h5678);
    check("s1_yaw", yaw_rt, 16'h1234);
`ifdef INERT_ACCEL_EN
    check("s1_ax", ax, 16'hABCD);
    check("s1_ay", ay, 16'h2211);
`endif
    extra_vld = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (vld) extra_vld++;
    end
    check("s1_vld_once", extra_vld, 0);
    check("s1_hold_ptch", ptch_rt, 16'h8000);
    check_reads("s1_rd_cmd");

    // Sequences 2/3: INT held high, next read starts right after vld.
    regs[7'h22] = 8'h80; regs[7'h23] = 8'h01;
    regs[7'h26] = 8'hEF; regs[7'h27] = 8'hBE;
    @(negedge clk);
    INT = 1'b1;
    run_seq(16'h8000, ndone, pch_when, seen);
    check("s2_vld_seen", seen, 1'b1);
    check("s2_vld_after_last", ndone, NRD);
    check("s2_ptch_at_A3", pch_when, 16'hA300);
    check("s2_ptch", ptch_rt, 16'h0180);
    check("s2_yaw", yaw_rt, 16'hBEEF);
    @(posedge clk);
    #1;
    check("b2b_vld_low", vld, 1'b0);
    check("b2b_wrt", wrt, 1'b1);
    check("b2b_cmd", cmd, 16'hA200);
    @(negedge clk);
    INT = 1'b0;
    run_seq(16'h0180, ndone, pch_when, seen);
    check("s3_vld_seen", seen, 1'b1);
    check("s3_vld_after_last", ndone, NRD);
    check_reads("s2_rd_cmd");
    check_reads("s3_rd_cmd");

    // Reset in the middle of the A5 transaction.
    @(negedge clk);
    INT = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (wrt && cmd == 16'hA500) break;
    end
    check("a5_reached", cmd, 16'hA500);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wrt", wrt, 1'b0);
    check("mid_rst_vld", vld, 1'b0);
    check("mid_rst_cmd", cmd, 16'h0000);
    check("mid_rst_ptch", ptch_rt, 16'h0000);
    check("mid_rst_roll", roll_rt, 16'h0000);
    check("mid_rst_yaw", yaw_rt, 16'h0000);
    check("mid_rst_init_done", init_done, 1'b0);
    check("mid_rst_state", state_dbg, 2'd0);
    INT = 1'b0;
    repeat (2) @(negedge clk);
    rd_ix = got_q.size();
    rst_n = 1'b1;
    settle_cfg("rerun");

    check("no_wrt_overlap", overlap_err, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
